button_conditioner: RTL



---
 rtl/button_conditioner_pkg.sv | 15 +
 rtl/button_conditioner_if.sv | 19 +
 rtl/button_conditioner_debounce_bit.sv | 77 +++++++
 rtl/button_conditioner.sv | 31 +++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the button conditioner.
//   NUM_BTNS                : number of conditioned button lines (bits [NUM_BTNS:1])
//   DEFAULT_DEBOUNCE_CYCLES : default stability count before an output flips
//   cnt_width()             : per-bit counter width, never narrower than 1
package btn_pkg;

    localparam int unsigned NUM_BTNS                = 3;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    // Counter must hold 0 .. cycles-1; a single-cycle debounce still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles <= 32'd1) ? 32'd1 : 32'($clog2(cycles));
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the raw switch lines, the conditioner and the sequence FSM.
//   btn_raw : raw asynchronous button lines
//   b       : debounced levels
//   b_rise  : one-cycle pulse on each debounced 0->1 transition
//   busy    : a change is pending on at least one bit
//   master  : the side driving raw buttons and consuming clean levels
//   slave   : the conditioner itself
interface button_conditioner_if;
    import btn_pkg::*;

    logic [NUM_BTNS:1] btn_raw;
    logic [NUM_BTNS:1] b;
    logic [NUM_BTNS:1] b_rise;
    logic              busy;

    modport master (output btn_raw, input b, b_rise, busy);
    modport slave  (input btn_raw, output b, b_rise, busy);

endinterface

// File: rtl/button_conditioner_debounce_bit.sv
// One conditioned button line: two-flop synchronizer, saturating stability
// counter, debounced level and registered rise pulse.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous raw button input
//   level      : debounced level
//   rise       : one-cycle pulse after level goes 0->1
//   busy       : counter non-zero (a change is pending)
module debounce_bit import btn_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic busy
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("debounce_bit: DEBOUNCE_CYCLES must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             level_n;
    logic             rise_n;
    logic             busy_n;

    // Synchronizer: back-to-back flops, nothing in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Next-state: any agreement with the current level discards the pending change.
    always_comb begin
        cnt_n   = cnt;
        level_n = level;
        if (sync2 == level) begin
            cnt_n = '0;
        end else if (cnt == CNT_MAX) begin
            level_n = sync2;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end
        rise_n = level_n & ~level;
        busy_n = (cnt_n != '0);
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            level <= level_n;
            rise  <= rise_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTNS raw button lines for the sequence FSM: each bit is
// synchronized and debounced independently.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of the button bus (btn_raw in; b, b_rise, busy out)
module button_conditioner import btn_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTNS:1] busy_bit;

    for (genvar i = 1; i <= NUM_BTNS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.btn_raw[i]),
            .level (bus.b[i]),
            .rise  (bus.b_rise[i]),
            .busy  (busy_bit[i])
        );
    end

    // Per-bit busy terms are flop outputs, so this stays coincident with counter state.
    assign bus.busy = |busy_bit;

endmodule
